// File: rtl/hilo_muldiv_if.sv
// Operation request / HI-LO result bundle for hilo_muldiv.
// The master (execute stage) drives start/op/a/b/flush; the slave returns status and the HI/LO registers.
interface hilo_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv.sv
// Multi-cycle shift-add multiplier / restoring divider owning the architectural HI/LO registers.
// Define HILO_MUL_EARLY_OUT_EN to let multiply leave RUN once the remaining multiplier bits are all zero.
module hilo_muldiv #(
  parameter int unsigned WIDTH         = 32,
  parameter logic [4:0]  MULT_CONTROL  = 5'b11000,
  parameter logic [4:0]  MULTU_CONTROL = 5'b11001,
  parameter logic [4:0]  DIV_CONTROL   = 5'b11010,
  parameter logic [4:0]  DIVU_CONTROL  = 5'b11011,
  parameter logic [4:0]  MTHI_CONTROL  = 5'b10001,
  parameter logic [4:0]  MTLO_CONTROL  = 5'b10011
) (
  input logic            clk,
  input logic            resetn,
  hilo_muldiv_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_a_raw;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;   // multiplier for mul, divisor for div
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic [CW-1:0]      r_cnt;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_is_signed;
  logic               w_muldiv;
  logic               w_is_mthi;
  logic               w_is_mtlo;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  logic [2*WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0]   w_mplier_shr;
  logic [WIDTH:0]     w_rem_shift;
  logic [WIDTH:0]     w_rem_sub;
  logic               w_q_bit;
  logic               w_last;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot_s;
  logic [WIDTH-1:0]   w_rem_s;
  logic [WIDTH-1:0]   w_hi_res;
  logic [WIDTH-1:0]   w_lo_res;
  logic [1:0]         w_state_nxt;

  // Operation decode
  assign w_is_mul    = (bus.op == MULT_CONTROL) | (bus.op == MULTU_CONTROL);
  assign w_is_div    = (bus.op == DIV_CONTROL)  | (bus.op == DIVU_CONTROL);
  assign w_is_signed = (bus.op == MULT_CONTROL) | (bus.op == DIV_CONTROL);
  assign w_muldiv    = w_is_mul | w_is_div;
  assign w_is_mthi   = (bus.op == MTHI_CONTROL);
  assign w_is_mtlo   = (bus.op == MTLO_CONTROL);

  // The most-negative value negates to itself, which reads correctly as unsigned 2^(WIDTH-1)
  assign w_a_neg = w_is_signed & bus.a[WIDTH-1];
  assign w_b_neg = w_is_signed & bus.b[WIDTH-1];
  assign w_a_mag = w_a_neg ? ('0 - bus.a) : bus.a;
  assign w_b_mag = w_b_neg ? ('0 - bus.b) : bus.b;

  assign w_acc_step   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_shr = r_mplier >> 1;

  assign w_rem_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_rem_sub   = w_rem_shift - {1'b0, r_mplier};
  assign w_q_bit     = ~w_rem_sub[WIDTH];

`ifdef HILO_MUL_EARLY_OUT_EN
  assign w_last = (r_cnt == CW'(1)) | (~r_is_div & (w_mplier_shr == '0));
`else
  assign w_last = (r_cnt == CW'(1));
`endif

  // Sign fix-up; divide-by-zero overrides so the signed path cannot disturb the all-ones quotient
  assign w_prod   = r_neg_res ? ('0 - r_acc)  : r_acc;
  assign w_quot_s = r_neg_res ? ('0 - r_quot) : r_quot;
  assign w_rem_s  = r_neg_rem ? ('0 - r_rem)  : r_rem;
  assign w_hi_res = r_is_div ? (r_b_zero ? r_a_raw : w_rem_s)  : w_prod[2*WIDTH-1:WIDTH];
  assign w_lo_res = r_is_div ? (r_b_zero ? '1      : w_quot_s) : w_prod[WIDTH-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.start && !bus.flush && w_muldiv) w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.flush)   w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_b_zero  <= 1'b0;
      r_a_raw   <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (r_state == S_FIX) && !bus.flush;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            if (w_is_mthi) r_hi <= bus.a;
            if (w_is_mtlo) r_lo <= bus.a;
            if (w_muldiv) begin
              r_is_div  <= w_is_div;
              r_neg_res <= w_a_neg ^ w_b_neg;
              r_neg_rem <= w_a_neg;
              r_b_zero  <= (bus.b == '0);
              r_a_raw   <= bus.a;
              r_acc     <= '0;
              r_mcand   <= {{WIDTH{1'b0}}, w_a_mag};
              r_mplier  <= w_b_mag;
              r_quot    <= w_a_mag;
              r_rem     <= '0;
              r_cnt     <= CW'(WIDTH);
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_is_div) begin
            r_rem  <= w_q_bit ? w_rem_sub[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
            r_quot <= {r_quot[WIDTH-2:0], w_q_bit};
          end else begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shr;
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.stall = r_busy | (bus.start & w_muldiv & ~bus.flush);

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv at WIDTH=32.
module tb_hilo_muldiv;

  localparam logic [4:0] OP_MULT  = 5'b11000;
  localparam logic [4:0] OP_MULTU = 5'b11001;
  localparam logic [4:0] OP_DIV   = 5'b11010;
  localparam logic [4:0] OP_DIVU  = 5'b11011;
  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MTLO  = 5'b10011;

`ifdef HILO_MUL_EARLY_OUT_EN
  localparam int LAT_B7 = 5;
  localparam int LAT_B3 = 4;
`else
  localparam int LAT_B7 = 34;
  localparam int LAT_B3 = 34;
`endif
  localparam int LAT_FULL = 34;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.WIDTH(32)) bus ();

  hilo_muldiv #(
    .WIDTH(32),
    .MULT_CONTROL(OP_MULT), .MULTU_CONTROL(OP_MULTU),
    .DIV_CONTROL(OP_DIV),   .DIVU_CONTROL(OP_DIVU),
    .MTHI_CONTROL(OP_MTHI), .MTLO_CONTROL(OP_MTLO)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.start = 1'b0;
    bus.op    = 5'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.flush = 1'b0;
  endtask

  // Issues one mul/div and returns in its done cycle (or after a cycle budget)
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic stall0, output logic busy1);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    #1;
    stall0 = bus.stall;
    tick();
    bus.start = 1'b0;
    busy1 = bus.busy;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic mt_write(input logic [4:0] op, input logic [31:0] a);
    bus.op = op; bus.a = a; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    resetn = 1'b0;
    tick(); tick();
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected %h", bus.lo, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_mthi_mtlo;
    mt_write(OP_MTHI, 32'h11);
    checks++; if (bus.hi !== 32'h11) begin failures++; $display("FAIL mthi_hi: got %h expected %h", bus.hi, 32'h11); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mthi_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mthi_done: got %b expected 0", bus.done); end
    mt_write(OP_MTLO, 32'h22);
    checks++; if (bus.lo !== 32'h22) begin failures++; $display("FAIL mtlo_lo: got %h expected %h", bus.lo, 32'h22); end
    // flush suppresses MTHI
    bus.flush = 1'b1;
    mt_write(OP_MTHI, 32'h99);
    bus.flush = 1'b0;
    checks++; if (bus.hi !== 32'h11) begin failures++; $display("FAIL mthi_flush: got %h expected %h", bus.hi, 32'h11); end
    // flush suppresses a mul start and its stall
    bus.op = OP_MULT; bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL flush_start_stall: got %b expected 0", bus.stall); end
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_start_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_mult;
    int lat; logic s0, b1;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, s0, b1);
    checks++; if (s0 !== 1'b1) begin failures++; $display("FAIL mult_stall_issue: got %b expected 1", s0); end
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL mult_busy_t1: got %b expected 1", b1); end
    checks++; if (lat !== LAT_B7) begin failures++; $display("FAIL mult_latency: got %0d expected %0d", lat, LAT_B7); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi: got %h expected %h", bus.hi, 32'hFFFFFFFF); end
    checks++; if (bus.lo !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_lo: got %h expected %h", bus.lo, 32'hFFFFFFEB); end
    tick();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse: got %b expected 0", bus.done); end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, s0, b1);
    checks++; if (lat !== LAT_FULL) begin failures++; $display("FAIL multu_max_latency: got %0d expected %0d", lat, LAT_FULL); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_max_hi: got %h expected %h", bus.hi, 32'hFFFFFFFE); end
    checks++; if (bus.lo !== 32'h00000001) begin failures++; $display("FAIL multu_max_lo: got %h expected %h", bus.lo, 32'h1); end
    run_op(OP_MULT, 32'h80000000, 32'h80000000, lat, s0, b1);
    checks++; if (bus.hi !== 32'h40000000) begin failures++; $display("FAIL mult_minneg_hi: got %h expected %h", bus.hi, 32'h40000000); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL mult_minneg_lo: got %h expected %h", bus.lo, 32'h0); end
    tick();
  endtask

  task automatic test_div;
    int lat; logic s0, b1;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, s0, b1);
    checks++; if (lat !== LAT_FULL) begin failures++; $display("FAIL div_latency: got %0d expected %0d", lat, LAT_FULL); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_lo: got %h expected %h", bus.lo, 32'hFFFFFFFD); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_hi: got %h expected %h", bus.hi, 32'hFFFFFFFF); end
    run_op(OP_DIVU, 32'd7, 32'd2, lat, s0, b1);
    checks++; if (bus.lo !== 32'd3) begin failures++; $display("FAIL divu_lo: got %h expected %h", bus.lo, 32'd3); end
    checks++; if (bus.hi !== 32'd1) begin failures++; $display("FAIL divu_hi: got %h expected %h", bus.hi, 32'd1); end
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, lat, s0, b1);
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_negdivisor_lo: got %h expected %h", bus.lo, 32'hFFFFFFFD); end
    checks++; if (bus.hi !== 32'd1) begin failures++; $display("FAIL div_negdivisor_hi: got %h expected %h", bus.hi, 32'd1); end
    run_op(OP_DIV, 32'd5, 32'd0, lat, s0, b1);
    checks++; if (lat !== LAT_FULL) begin failures++; $display("FAIL div0_latency: got %0d expected %0d", lat, LAT_FULL); end
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL div0_lo: got %h expected %h", bus.lo, 32'hFFFFFFFF); end
    checks++; if (bus.hi !== 32'd5) begin failures++; $display("FAIL div0_hi: got %h expected %h", bus.hi, 32'd5); end
    tick();
  endtask

  task automatic test_flush;
    int ndone;
    mt_write(OP_MTHI, 32'h11);
    mt_write(OP_MTLO, 32'h22);
    bus.op = OP_DIV; bus.a = 32'd100; bus.b = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL flush_busy_t1: got %b expected 1", bus.busy); end
    repeat (3) tick();
    bus.op = OP_MTHI; bus.a = 32'hAB; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_run_busy: got %b expected 0", bus.busy); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) ndone++;
      tick();
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL flush_run_done: got %0d expected 0", ndone); end
    checks++; if (bus.hi !== 32'h11) begin failures++; $display("FAIL flush_run_hi: got %h expected %h", bus.hi, 32'h11); end
    checks++; if (bus.lo !== 32'h22) begin failures++; $display("FAIL flush_run_lo: got %h expected %h", bus.lo, 32'h22); end
    // flush landing on the FIX cycle
    bus.op = OP_DIVU; bus.a = 32'd9; bus.b = 32'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (32) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL flush_fix_done: got %b expected 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_fix_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.lo !== 32'h22) begin failures++; $display("FAIL flush_fix_lo: got %h expected %h", bus.lo, 32'h22); end
  endtask

  task automatic test_reset_mid;
    int ndone;
    mt_write(OP_MTHI, 32'h33);
    bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL rstmid_hi: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL rstmid_lo: got %h expected %h", bus.lo, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) ndone++;
      tick();
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL rstmid_done: got %0d expected 0", ndone); end
  endtask

  task automatic test_early_out;
    int lat; logic s0, b1;
    run_op(OP_MULTU, 32'd5, 32'd3, lat, s0, b1);
    checks++; if (lat !== LAT_B3) begin failures++; $display("FAIL early_latency: got %0d expected %0d", lat, LAT_B3); end
    checks++; if (bus.lo !== 32'd15) begin failures++; $display("FAIL early_lo: got %h expected %h", bus.lo, 32'd15); end
    checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL early_hi: got %h expected %h", bus.hi, 32'd0); end
    tick();
  endtask

  task automatic test_back_to_back;
    int lat; logic s0, b1;
    run_op(OP_MULTU, 32'd6, 32'd7, lat, s0, b1);
    checks++; if (lat !== LAT_B7) begin failures++; $display("FAIL b2b_mul_latency: got %0d expected %0d", lat, LAT_B7); end
    checks++; if (bus.lo !== 32'd42) begin failures++; $display("FAIL b2b_mul_lo: got %h expected %h", bus.lo, 32'd42); end
    run_op(OP_DIVU, 32'd100, 32'd7, lat, s0, b1);
    checks++; if (s0 !== 1'b1) begin failures++; $display("FAIL b2b_div_stall: got %b expected 1", s0); end
    checks++; if (lat !== LAT_FULL) begin failures++; $display("FAIL b2b_div_latency: got %0d expected %0d", lat, LAT_FULL); end
    checks++; if (bus.lo !== 32'd14) begin failures++; $display("FAIL b2b_div_lo: got %h expected %h", bus.lo, 32'd14); end
    checks++; if (bus.hi !== 32'd2) begin failures++; $display("FAIL b2b_div_hi: got %h expected %h", bus.hi, 32'd2); end
    mt_write(OP_MTLO, 32'h55);
    checks++; if (bus.lo !== 32'h55) begin failures++; $display("FAIL b2b_mtlo_lo: got %h expected %h", bus.lo, 32'h55); end
    checks++; if (bus.hi !== 32'd2) begin failures++; $display("FAIL b2b_mtlo_hi: got %h expected %h", bus.hi, 32'd2); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_flush();
    test_reset_mid();
    test_early_out();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It executes the HI/LO class of ALU control codes: MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits in the execute stage beside the single-cycle ALU, and its stall output holds the pipeline while an operation runs. HI and LO are read directly by the MFHI/MFLO path.

## Interface
Parameters:
- `WIDTH`, default 32: operand width and width of each of HI and LO.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: request an operation this cycle.
- `op` in 5: ALU control code from `defines.vh`. Accepted codes: `MULT_CONTROL`, `MULTU_CONTROL`, `DIV_CONTROL`, `DIVU_CONTROL`, `MTHI_CONTROL`, `MTLO_CONTROL`. Any other code with `start` high is ignored.
- `a` in WIDTH: rs operand (multiplicand, dividend, or MTHI/MTLO data).
- `b` in WIDTH: rt operand (multiplier or divisor).
- `flush` in 1: cancel the in-flight operation.
- `busy` out 1: registered; high while the state is RUN or FIX.
- `stall` out 1: combinational. Equals `busy | (start & op is MULT/MULTU/DIV/DIVU & ~flush)`.
- `done` out 1: registered one-cycle pulse; HI/LO hold the new result in this cycle.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States are IDLE, RUN and FIX. Reset (`resetn`=0 at an edge) forces IDLE with `hi`=`lo`=0 and `busy`=`done`=0, including mid-operation.
- IDLE, MTHI/MTLO with `start`: `hi` or `lo` is set to `a` at the edge. State stays IDLE and `done` is not pulsed.
- IDLE, mul/div with `start`: latch the operation type and signedness. Latch |a| and |b| (magnitudes for signed ops; raw values for unsigned ops). Latch the sign flags. Set the iteration counter to WIDTH. Go to RUN.
- RUN, multiply: one shift-add per cycle on a 2·WIDTH accumulator. The LSB of the multiplier register selects the add; the multiplier register shifts right by 1.
- RUN, divide: one restoring step per cycle on a (WIDTH+1)-bit partial remainder. Shift in the next dividend bit, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- RUN to FIX: after WIDTH iterations. See Configuration for early exit.
- FIX, one cycle:
  - Signed multiply: negate the 2·WIDTH product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - At the edge: write `hi` = upper half or remainder, `lo` = lower half or quotient. Pulse `done` and go to IDLE.
- Divide by zero (`b`=0, signed or unsigned): runs the full latency, then `lo` = all ones and `hi` = raw `a`. No trap.
- The most-negative operand is handled as magnitude 2^(WIDTH-1), which fits unsigned.
- `start` while `busy`: ignored. Upstream must respect `stall`.
- `flush` in RUN or FIX: return to IDLE next edge. No `done` pulse; HI/LO unchanged.
- `flush` together with `start` in IDLE: `flush` wins and nothing is started. MTHI/MTLO are also suppressed.
- MTHI/MTLO in the same cycle as `done`: allowed, since the state is already IDLE.

## Timing
- `start` is sampled at edge T.
- `busy` is high in cycles T+1 through T+WIDTH+1: WIDTH RUN cycles plus 1 FIX cycle.
- `done` is high in cycle T+WIDTH+2 (T+34 for WIDTH=32), with new `hi`/`lo` valid in that cycle.
- A new mul/div may be issued in the `done` cycle.
- MTHI/MTLO: value visible in cycle T+1.
- `stall` is high in cycle T itself through T+WIDTH+1, so the issuing instruction is held.

## Configuration
- `HILO_MUL_EARLY_OUT_EN` defined:
  - In RUN for multiply, exit to FIX after the iteration in which the shifted multiplier register becomes zero, or after WIDTH iterations, whichever is first.
  - Latency becomes k+2 cycles, where k = max(1, position of the highest set bit of |b| + 1).
  - Divide is unaffected.
- Not defined: multiply always takes WIDTH iterations. There is no early-exit logic.

## Test plan
All scenarios use WIDTH=32.
- MULT a=0xFFFFFFFD (-3), b=7: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. `done` at T+34 without the macro.
- MULTU a=b=0xFFFFFFFF: `hi`=0xFFFFFFFE, `lo`=0x00000001. MULT a=b=0x80000000: `hi`=0x40000000, `lo`=0.
- DIV a=0xFFFFFFF9 (-7), b=2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=7, b=2: `lo`=3, `hi`=1.
- DIV a=5, b=0: at T+34, `lo`=0xFFFFFFFF, `hi`=5.
- Flush and reset during an operation:
  - Preload HI/LO with MTHI 0x11 and MTLO 0x22. DIV with `flush` at T+10: `busy`=0 at T+11, no `done`, HI/LO stay 0x11/0x22.
  - `resetn`=0 at T+10: HI=LO=0.
- MULTU a=5, b=3 with `HILO_MUL_EARLY_OUT_EN`: `done` at T+4, `lo`=15, `hi`=0. Without the macro: `done` at T+34.
